// File: rtl/i2c_arb_pkg.sv
// Shared types and sizes for the two-requester I2C core arbiter.
// Pure definitions: no latency, no flow control.
package i2c_arb_pkg;

    localparam int N_REQ           = 2;
    localparam int DEV_W           = 7;
    localparam int BYTE_W          = 8;
    localparam int TMO_W           = 16;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // Pointer value that favours the requester after the given one-hot owner.
    function automatic logic next_ptr(input logic [N_REQ-1:0] owner);
        return owner[0];
    endfunction

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-way round-robin pick (combinational) and priority pointer (registered).
// Pointer moves only on advance; no backpressure.
module i2c_arb_rr
    import i2c_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [N_REQ-1:0] owner,
    output logic [N_REQ-1:0] pick
);

    // ptr = 0: requester 0 has priority on a tie; 1: requester 1.
    logic ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (owner != '0)) begin
            ptr <= next_ptr(owner);
        end
    end

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C core between two requesters: IDLE -> ISSUE -> WAIT -> RELEASE.
// Grant one edge after arbitration; responses forwarded with one registered cycle; WAIT bounded by a timeout.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int SWAP_RD     = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rqt_0,
    input  logic              cmd_0,
    input  logic [DEV_W-1:0]  addr_dev_0,
    input  logic [BYTE_W-1:0] addr_reg_H_0,
    input  logic [BYTE_W-1:0] addr_reg_L_0,
    input  logic [BYTE_W-1:0] data_wr_H_0,
    input  logic [BYTE_W-1:0] data_wr_L_0,
    output logic [BYTE_W-1:0] data_rd_0,
    output logic              data_rdy_0,
    output logic              done_0,
    output logic              err_0,

    input  logic              rqt_1,
    input  logic              cmd_1,
    input  logic [DEV_W-1:0]  addr_dev_1,
    input  logic [BYTE_W-1:0] addr_reg_H_1,
    input  logic [BYTE_W-1:0] addr_reg_L_1,
    input  logic [BYTE_W-1:0] data_wr_H_1,
    input  logic [BYTE_W-1:0] data_wr_L_1,
    output logic [BYTE_W-1:0] data_rd_1,
    output logic              data_rdy_1,
    output logic              done_1,
    output logic              err_1,

    output logic              core_rqt,
    output logic              core_cmd,
    output logic [DEV_W-1:0]  core_addr_dev,
    output logic [BYTE_W-1:0] core_addr_reg_H,
    output logic [BYTE_W-1:0] core_addr_reg_L,
    output logic [BYTE_W-1:0] core_data_wr_H,
    output logic [BYTE_W-1:0] core_data_wr_L,
    input  logic [BYTE_W-1:0] core_data_rd,
    input  logic              core_data_rdy,
    input  logic              core_done,

    output logic [N_REQ-1:0]  grant
);

    localparam logic [TMO_W:0] TMO_LIM = TIMEOUT_CYC[TMO_W:0];

    // Read-byte swapping is reserved for a later revision and has no effect.
    if (SWAP_RD != 0) begin : g_swap_rd_rsvd
    end

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [N_REQ-1:0]   pick;
    logic               arm;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W:0]     tmo_inc;
    logic               tmo_hit;
    logic               take;

    i2c_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({rqt_1, rqt_0}),
        .advance (state == ST_RELEASE),
        .owner   (grant),
        .pick    (pick)
    );

    // arm holds off arbitration for one edge after reset release.
    assign take    = (state == ST_IDLE) && arm && (pick != '0);
    assign tmo_inc = {1'b0, tmo_cnt} + {{TMO_W{1'b0}}, 1'b1};
    assign tmo_hit = (tmo_inc >= TMO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (take) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT:    if (core_done || tmo_hit) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm             <= 1'b0;
            grant           <= '0;
            tmo_cnt         <= '0;
            core_rqt        <= 1'b0;
            core_cmd        <= 1'b0;
            core_addr_dev   <= '0;
            core_addr_reg_H <= '0;
            core_addr_reg_L <= '0;
            core_data_wr_H  <= '0;
            core_data_wr_L  <= '0;
            data_rd_0       <= '0;
            data_rd_1       <= '0;
            data_rdy_0      <= 1'b0;
            data_rdy_1      <= 1'b0;
            done_0          <= 1'b0;
            done_1          <= 1'b0;
            err_0           <= 1'b0;
            err_1           <= 1'b0;
        end else begin
            arm        <= 1'b1;
            data_rdy_0 <= 1'b0;
            data_rdy_1 <= 1'b0;
            done_0     <= 1'b0;
            done_1     <= 1'b0;
            err_0      <= 1'b0;
            err_1      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        grant    <= pick;
                        core_rqt <= 1'b1;
                        if (pick[0]) begin
                            core_cmd        <= cmd_0;
                            core_addr_dev   <= addr_dev_0;
                            core_addr_reg_H <= addr_reg_H_0;
                            core_addr_reg_L <= addr_reg_L_0;
                            core_data_wr_H  <= data_wr_H_0;
                            core_data_wr_L  <= data_wr_L_0;
                        end else begin
                            core_cmd        <= cmd_1;
                            core_addr_dev   <= addr_dev_1;
                            core_addr_reg_H <= addr_reg_H_1;
                            core_addr_reg_L <= addr_reg_L_1;
                            core_data_wr_H  <= data_wr_H_1;
                            core_data_wr_L  <= data_wr_L_1;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    data_rdy_0 <= core_data_rdy && grant[0];
                    data_rdy_1 <= core_data_rdy && grant[1];
                    if (core_data_rdy && grant[0]) data_rd_0 <= core_data_rd;
                    if (core_data_rdy && grant[1]) data_rd_1 <= core_data_rd;
                    // A completion in the timeout cycle is a success, not an error.
                    if (core_done) begin
                        core_rqt <= 1'b0;
                        done_0   <= grant[0];
                        done_1   <= grant[1];
                    end else if (tmo_hit) begin
                        core_rqt <= 1'b0;
                        done_0   <= grant[0];
                        done_1   <= grant[1];
                        err_0    <= grant[0];
                        err_1    <= grant[1];
                    end else begin
                        tmo_cnt <= tmo_inc[TMO_W-1:0];
                    end
                end
                ST_RELEASE: begin
                    grant   <= '0;
                    tmo_cnt <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter with a 16-cycle timeout.
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       rqt_0, cmd_0, rqt_1, cmd_1;
    logic [6:0] addr_dev_0, addr_dev_1;
    logic [7:0] addr_reg_H_0, addr_reg_L_0, data_wr_H_0, data_wr_L_0;
    logic [7:0] addr_reg_H_1, addr_reg_L_1, data_wr_H_1, data_wr_L_1;
    logic [7:0] data_rd_0, data_rd_1;
    logic       data_rdy_0, done_0, err_0, data_rdy_1, done_1, err_1;
    logic       core_rqt, core_cmd;
    logic [6:0] core_addr_dev;
    logic [7:0] core_addr_reg_H, core_addr_reg_L, core_data_wr_H, core_data_wr_L;
    logic [7:0] core_data_rd;
    logic       core_data_rdy, core_done;
    logic [1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;
    int n_d0, n_d1, n_err, n_bad, lowc;
    logic [1:0] gq[$];
    int         gaps[$];

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYC(16), .SWAP_RD(0)) dut (
        .clk(clk), .rst(rst),
        .rqt_0(rqt_0), .cmd_0(cmd_0), .addr_dev_0(addr_dev_0),
        .addr_reg_H_0(addr_reg_H_0), .addr_reg_L_0(addr_reg_L_0),
        .data_wr_H_0(data_wr_H_0), .data_wr_L_0(data_wr_L_0),
        .data_rd_0(data_rd_0), .data_rdy_0(data_rdy_0), .done_0(done_0), .err_0(err_0),
        .rqt_1(rqt_1), .cmd_1(cmd_1), .addr_dev_1(addr_dev_1),
        .addr_reg_H_1(addr_reg_H_1), .addr_reg_L_1(addr_reg_L_1),
        .data_wr_H_1(data_wr_H_1), .data_wr_L_1(data_wr_L_1),
        .data_rd_1(data_rd_1), .data_rdy_1(data_rdy_1), .done_1(done_1), .err_1(err_1),
        .core_rqt(core_rqt), .core_cmd(core_cmd), .core_addr_dev(core_addr_dev),
        .core_addr_reg_H(core_addr_reg_H), .core_addr_reg_L(core_addr_reg_L),
        .core_data_wr_H(core_data_wr_H), .core_data_wr_L(core_data_wr_L),
        .core_data_rd(core_data_rd), .core_data_rdy(core_data_rdy), .core_done(core_done),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Plays the core: done two WAIT cycles after issue; logs grant order and idle gaps.
    task automatic serve(input int ncyc, input bit drop_on_done);
        int   wcnt;
        logic prev;
        wcnt = 0;
        prev = core_rqt;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (core_rqt && !prev) begin
                gq.push_back(grant);
                gaps.push_back(lowc);
            end
            if (core_rqt) lowc = 0; else lowc++;
            prev = core_rqt;
            if ((done_0 || err_0 || data_rdy_0) && !grant[0]) n_bad++;
            if ((done_1 || err_1 || data_rdy_1) && !grant[1]) n_bad++;
            if (err_0 || err_1) n_err++;
            if (done_0) begin n_d0++; if (drop_on_done) rqt_0 = 1'b0; end
            if (done_1) begin n_d1++; if (drop_on_done) rqt_1 = 1'b0; end
            core_done = 1'b0;
            if (core_rqt) begin
                wcnt++;
                if (wcnt == 3) core_done = 1'b1;
            end else begin
                wcnt = 0;
            end
        end
        core_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rqt_0 = 1'b1; cmd_0 = 1'b0; addr_dev_0 = 7'h36;
        addr_reg_H_0 = 8'h01; addr_reg_L_0 = 8'h00; data_wr_H_0 = 8'h00; data_wr_L_0 = 8'h01;
        rqt_1 = 1'b0; cmd_1 = 1'b1; addr_dev_1 = 7'h50;
        addr_reg_H_1 = 8'h12; addr_reg_L_1 = 8'h34; data_wr_H_1 = 8'h56; data_wr_L_1 = 8'h78;
        core_data_rd = 8'h00; core_data_rdy = 1'b0; core_done = 1'b0;
        n_d0 = 0; n_d1 = 0; n_err = 0; n_bad = 0; lowc = 0;

        // Reset state, with rqt_0 already pending.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_core_rqt", core_rqt, 1'b0);
        chk("rst_core_dev", core_addr_dev, 7'h00);
        chk("rst_core_wrl", core_data_wr_L, 8'h00);
        chk("rst_strobes", {done_0, done_1, err_0, err_1, data_rdy_0, data_rdy_1}, 6'b0);
        chk("rst_data_rd", {data_rd_0, data_rd_1}, 16'h0000);

        // Single write from requester 0; first arbitration on the second edge.
        rst = 1'b0;
        tick();
        chk("w0_no_arb_edge1", core_rqt, 1'b0);
        tick();
        chk("w0_core_rqt", core_rqt, 1'b1);
        chk("w0_grant", grant, 2'b01);
        chk("w0_fields", {core_cmd, core_addr_dev, core_addr_reg_H, core_addr_reg_L,
                          core_data_wr_H, core_data_wr_L}, {1'b0, 7'h36, 32'h0100_0001});
        tick();
        chk("w0_wait_rqt", core_rqt, 1'b1);
        addr_dev_0 = 7'h7F;
        data_wr_L_0 = 8'hFF;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rqt_0 = 1'b0;
        chk("w0_fields_held", {core_addr_dev, core_data_wr_L}, {7'h36, 8'h01});
        chk("w0_done", {done_0, err_0, done_1, err_1}, 4'b1000);
        chk("w0_rqt_drop", core_rqt, 1'b0);
        tick();
        chk("w0_done_1cyc", done_0, 1'b0);
        chk("w0_grant_idle", grant, 2'b00);
        tick();

        // Simultaneous requests after reset: 0 then 1, two idle cycles between.
        addr_dev_0 = 7'h36;
        data_wr_L_0 = 8'h01;
        rqt_0 = 1'b1;
        rqt_1 = 1'b1;
        do_reset();
        gq.delete(); gaps.delete();
        n_d0 = 0; n_d1 = 0; n_err = 0; lowc = 0;
        serve(40, 1'b1);
        chk("tie_ngrant", gq.size(), 2);
        if (gq.size() >= 2) begin
            chk("tie_first", gq[0], 2'b01);
            chk("tie_second", gq[1], 2'b10);
            chk("tie_gap", gaps[1], 2);
        end
        chk("tie_done0", n_d0, 1);
        chk("tie_done1", n_d1, 1);
        chk("tie_err", n_err, 0);

        // Responses outside WAIT are ignored.
        core_data_rdy = 1'b1; core_data_rd = 8'h33; core_done = 1'b1;
        tick();
        core_data_rdy = 1'b0; core_done = 1'b0;
        chk("idle_ignore", {data_rdy_0, data_rdy_1, done_0, done_1, core_rqt}, 5'b0);
        chk("idle_rd_hold", data_rd_1, 8'h00);

        // Read by requester 1.
        rqt_1 = 1'b1;
        tick();
        chk("r1_grant", grant, 2'b10);
        chk("r1_fields", {core_cmd, core_addr_dev, core_addr_reg_H}, {1'b1, 7'h50, 8'h12});
        tick();
        core_data_rdy = 1'b1; core_data_rd = 8'hA5;
        tick();
        core_data_rdy = 1'b0;
        chk("r1_rdy", {data_rdy_1, data_rdy_0}, 2'b10);
        chk("r1_data", data_rd_1, 8'hA5);
        chk("r1_data0", data_rd_0, 8'h00);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rqt_1 = 1'b0;
        chk("r1_rdy_pulse", data_rdy_1, 1'b0);
        chk("r1_done", {done_1, err_1, done_0}, 3'b100);
        tick();
        tick();

        // Timeout: no core_done for 16 WAIT cycles.
        rqt_0 = 1'b1;
        tick();
        chk("to_grant", grant, 2'b01);
        tick();
        repeat (15) tick();
        chk("to_not_early", {done_0, err_0, core_rqt}, 3'b001);
        tick();
        chk("to_strobe", {done_0, err_0, done_1, err_1}, 4'b1100);
        chk("to_rqt", core_rqt, 1'b0);
        rqt_0 = 1'b0;
        tick();
        chk("to_pulse", {done_0, err_0}, 2'b00);
        chk("to_idle", grant, 2'b00);
        tick();

        // Reset during WAIT: immediate drop, no completion, then a clean retry.
        rqt_1 = 1'b1;
        tick();
        tick();
        chk("ar_in_wait", core_rqt, 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_async_rqt", core_rqt, 1'b0);
        chk("ar_async_grant", grant, 2'b00);
        tick();
        chk("ar_no_done", done_1, 1'b0);
        rst = 1'b0;
        tick();
        chk("ar_hold", {core_rqt, done_1}, 2'b00);
        tick();
        chk("ar_regrant", {core_rqt, grant}, 3'b110);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rqt_1 = 1'b0;
        chk("ar_done", {done_1, err_1}, 2'b10);
        tick();
        tick();

        // Both held continuously: alternation without starvation.
        rqt_0 = 1'b1;
        rqt_1 = 1'b1;
        gq.delete(); gaps.delete();
        n_err = 0;
        serve(22, 1'b0);
        chk("alt_ngrant", gq.size() >= 4, 1'b1);
        if (gq.size() >= 4) begin
            chk("alt_seq", {gq[0], gq[1], gq[2], gq[3]}, 8'b01_10_01_10);
        end
        chk("alt_err", n_err, 0);
        chk("nonowner_strobes", n_bad, 0);
        rqt_0 = 1'b0;
        rqt_1 = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 65535: maximum cycles a granted transaction may wait for core done.
REQ-002 Parameter SWAP_RD, default 0: reserved, tied off; no functional effect.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rqt_0, rqt_1  in  1 each  requester level request; held high until that requester's done pulse.
REQ-006 cmd_N  in  1  per requester: 0 write, 1 read.
REQ-007 addr_dev_N  in  7  per requester: I2C device address.
REQ-008 addr_reg_H_N, addr_reg_L_N  in  8 each  per requester: register address.
REQ-009 data_wr_H_N, data_wr_L_N  in  8 each  per requester: write data.
REQ-010 data_rd_N  out  8  per requester: read data, valid with data_rdy_N.
REQ-011 data_rdy_N, done_N, err_N  out  1 each  per requester: read-valid, completion and timeout strobes.
REQ-012 core_rqt  out  1  request to the shared I2C core.
REQ-013 core_cmd, core_addr_dev, core_addr_reg_H/L, core_data_wr_H/L  out  1/7/8/8/8/8  fields to the core.
REQ-014 core_data_rd  in  8; core_data_rdy  in  1; core_done  in  1  core responses.
REQ-015 grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RELEASE.
REQ-017 IDLE: any rqt_N high selects a winner by round-robin and transitions to ISSUE on the next edge.
REQ-018 Both requests high in the same cycle: requester not granted last wins; the first arbitration after reset favours requester 0.
REQ-019 On grant, all winner fields are registered into core_* outputs and held stable until RELEASE.
REQ-020 Requester inputs changing after grant have no effect on the current transaction.
REQ-021 ISSUE lasts exactly 1 cycle with core_rqt=1, then the FSM enters WAIT.
REQ-022 core_rqt stays high through WAIT and drops in the cycle after core_done is seen.
REQ-023 WAIT: core_data_rdy is forwarded to data_rdy_<owner>, and core_data_rd to data_rd_<owner>, with 1-cycle registered latency.
REQ-024 WAIT: core_done=1 moves the FSM to RELEASE and pulses done_<owner> for exactly 1 cycle, 1 cycle after core_done.
REQ-025 WAIT timeout counter is 16 bits, cleared on entry to WAIT.
REQ-026 Counter reaching TIMEOUT_CYC before core_done: pulse done_<owner> and err_<owner> together for 1 cycle, drop core_rqt, enter RELEASE.
REQ-027 core_done and timeout in the same cycle: core_done wins and err stays 0.
REQ-028 RELEASE lasts 1 cycle.
REQ-029 RELEASE: the round-robin pointer advances past the owner, grant clears to 00, and the FSM returns to IDLE.
REQ-030 Back-to-back grants: minimum 2 idle cycles between core_rqt deassertion and the next core_rqt assertion.
REQ-031 data_rdy_N, done_N and err_N of the non-owner are 0 at all times.
REQ-032 core_data_rdy or core_done received outside WAIT is ignored.
REQ-033 rqt_N dropping while granted does not abort the transaction; completion is still reported.

Reset
REQ-034 On rst: FSM=IDLE, grant=00, core_rqt=0, all core_* fields=0, all data_rd_N=0, all strobes=0, timeout counter=0, round-robin pointer=requester 0.
REQ-035 rst asserted mid-transaction drops core_rqt asynchronously, and no done_N is issued for the aborted transaction.
REQ-036 After rst deasserts, the first arbitration occurs no earlier than the second rising edge.

Structure
REQ-037 Package i2c_arb_pkg holds the FSM state encoding, the field widths (7/8), the requester count (2) and the TIMEOUT_CYC default.
REQ-038 Sub-module i2c_arb_rr implements the 2-way round-robin pick and pointer; all other logic is flat in i2c_arbiter.

Verification
REQ-039 rqt_0=1 with a write of dev 0x36, reg 0x0100, data 0x0001 -> core_* fields match, core_rqt rises 2 cycles later, core_done pulse -> done_0 1 cycle later, err_0=0.
REQ-040 rqt_0 and rqt_1 rise in the same cycle, each held through its own done -> grant order 01, 10 (0 first, then 1), exactly one done per requester, 2 idle cycles between the transactions.
REQ-041 Read by requester 1 with core_data_rdy and core_data_rd=0xA5 -> data_rdy_1=1 and data_rd_1=0xA5 1 cycle later; data_rdy_0 stays 0.
REQ-042 TIMEOUT_CYC=16 with core_done never asserted -> done_0=err_0=1 for 1 cycle after 16 WAIT cycles, core_rqt=0, FSM returns to IDLE.
REQ-043 rst pulsed during WAIT -> core_rqt=0 immediately, grant=00, no done strobe; a fresh request afterwards completes normally.
REQ-044 Requester 0 re-requests continuously while rqt_1 is held -> grants alternate 0,1,0,1 (no starvation).
